// File: rtl/bsg_lfsr_bank_if.sv
// Seed request, per-channel LFSR output, consume and lockup signals for bsg_lfsr_bank.
// The master drives seeds and yumis; the slave (the bank) drives state, valids and flags.
interface bsg_lfsr_bank_if #(
   parameter int width_p = 32,
   parameter int els_p   = 4
);
   localparam int id_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

   logic                       seed_v_i;
   logic [id_w_lp-1:0]         seed_id_i;
   logic [width_p-1:0]         seed_i;
   logic                       seed_ready_o;
   logic [els_p-1:0]           v_o;
   logic [els_p*width_p-1:0]   data_o;
   logic [els_p-1:0]           yumi_i;
   logic [els_p-1:0]           lockup_o;

   modport master (
      output seed_v_i, seed_id_i, seed_i, yumi_i,
      input  seed_ready_o, v_o, data_o, lockup_o
   );

   modport slave (
      input  seed_v_i, seed_id_i, seed_i, yumi_i,
      output seed_ready_o, v_o, data_o, lockup_o
   );
endinterface

// File: rtl/bsg_lfsr_bank.sv
// Bank of els_p Galois LFSRs; yumi/seed take effect next cycle; no backpressure except during warmup.
// Optional all-zero lockup recovery enabled by macro BSG_LFSR_BANK_LOCKUP_EN.
module bsg_lfsr_bank #(
   parameter int          width_p    = 32,
   parameter int          els_p      = 4,
   parameter logic [63:0] init_val_p = 64'd1,
   parameter logic [63:0] xor_mask_p = 64'hB400_0000,
   parameter int          steps_p    = 1,
   parameter int          warmup_p   = 0
) (
   input  logic                clk,
   input  logic                reset_n_i,
   bsg_lfsr_bank_if.slave      bus
);
   localparam int id_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam logic [width_p-1:0] init_lp = init_val_p[width_p-1:0];
   localparam logic [width_p-1:0] mask_lp = xor_mask_p[width_p-1:0];
   localparam logic [7:0]         warm_lp = 8'(warmup_p);

   if (mask_lp == '0) begin : g_bad_mask
      $error("bsg_lfsr_bank: xor_mask_p must be non-zero");
   end
   if (init_lp == '0) begin : g_bad_init
      $error("bsg_lfsr_bank: init_val_p must be non-zero");
   end

   typedef enum logic {WARMUP_S = 1'b0, RUN_S = 1'b1} state_e;

   // A zero-length warmup is indistinguishable from starting in RUN.
   localparam state_e reset_state_lp = (warmup_p == 0) ? RUN_S : WARMUP_S;

   state_e                          state_q, state_d;
   logic [7:0]                      cnt_q, cnt_d;
   logic [els_p-1:0][width_p-1:0]   st_q, st_d;
   logic [els_p-1:0]                lock_q, lock_d;
   logic                            run_q;

   function automatic logic [width_p-1:0] advance(input logic [width_p-1:0] s);
      logic [width_p-1:0] r;
      r = s;
      for (int i = 0; i < steps_p; i++) begin
         r = (r >> 1) ^ ({width_p{r[0]}} & mask_lp);
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      lock_d  = lock_q;
      if (state_q == WARMUP_S) begin
         cnt_d = cnt_q - 8'd1;
         if (cnt_q <= 8'd1) begin
            state_d = RUN_S;
         end
      end
      for (int c = 0; c < els_p; c++) begin
         // Out-of-range seed ids never match a channel, so they are silently dropped.
         if (run_q && bus.seed_v_i && (bus.seed_id_i == id_w_lp'(c))) begin
            st_d[c]   = bus.seed_i;
            lock_d[c] = 1'b0;
         end
`ifdef BSG_LFSR_BANK_LOCKUP_EN
         else if (st_q[c] == '0) begin
            st_d[c]   = init_lp;
            lock_d[c] = 1'b1;
         end
`endif
         else if (!run_q || bus.yumi_i[c]) begin
            st_d[c] = advance(st_q[c]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= reset_state_lp;
         run_q   <= (reset_state_lp == RUN_S);
         cnt_q   <= warm_lp;
         st_q    <= {els_p{init_lp}};
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= (state_d == RUN_S);
         cnt_q   <= cnt_d;
         st_q    <= st_d;
         lock_q  <= lock_d;
      end
   end

   assign bus.v_o          = {els_p{run_q}};
   assign bus.seed_ready_o = run_q;
   assign bus.data_o       = st_q;
   assign bus.lockup_o     = lock_q;
endmodule

// File: tb/tb_bsg_lfsr_bank.sv
// Self-checking bench for bsg_lfsr_bank: directed vectors plus a scoreboarded random run on an 8-bit, 2-channel bank.
// Honours BSG_LFSR_BANK_LOCKUP_EN when computing expected lockup behaviour.
module tb_bsg_lfsr_bank;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   bsg_lfsr_bank_if #(.width_p(8), .els_p(2)) if0();
   bsg_lfsr_bank_if #(.width_p(8), .els_p(2)) if1();
   bsg_lfsr_bank_if #(.width_p(8), .els_p(2)) if2();
   bsg_lfsr_bank_if #(.width_p(8), .els_p(3)) if3();

   bsg_lfsr_bank #(.width_p(8), .els_p(2), .init_val_p(64'h1), .xor_mask_p(64'hB8),
                   .steps_p(1), .warmup_p(0)) u0 (.clk(clk), .reset_n_i(reset_n), .bus(if0));
   bsg_lfsr_bank #(.width_p(8), .els_p(2), .init_val_p(64'h1), .xor_mask_p(64'hB8),
                   .steps_p(2), .warmup_p(0)) u1 (.clk(clk), .reset_n_i(reset_n), .bus(if1));
   bsg_lfsr_bank #(.width_p(8), .els_p(2), .init_val_p(64'h1), .xor_mask_p(64'hB8),
                   .steps_p(1), .warmup_p(3)) u2 (.clk(clk), .reset_n_i(reset_n), .bus(if2));
   bsg_lfsr_bank #(.width_p(8), .els_p(3), .init_val_p(64'h1), .xor_mask_p(64'hB8),
                   .steps_p(1), .warmup_p(0)) u3 (.clk(clk), .reset_n_i(reset_n), .bus(if3));

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [15:0] data;
      logic [1:0]  lock;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] m_st [2];
   logic [1:0] m_lock;

   function automatic logic [7:0] lfsr8(input logic [7:0] s, input int n);
      logic [7:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = {1'b0, r[7:1]} ^ (r[0] ? 8'hB8 : 8'h00);
      return r;
   endfunction

   task automatic model_reset();
      m_st[0] = 8'h01;
      m_st[1] = 8'h01;
      m_lock  = 2'b00;
      exp_q.delete();
   endtask

   // Drive one cycle on u0, push the model's prediction, then compare after the edge.
   task automatic drive_u0(input logic [1:0] y, input logic sv, input logic sid, input logic [7:0] sd);
      exp_t e;
      exp_t g;
      @(negedge clk);
      if0.yumi_i    = y;
      if0.seed_v_i  = sv;
      if0.seed_id_i = sid;
      if0.seed_i    = sd;
      for (int c = 0; c < 2; c++) begin
         if (sv && (sid == 1'(c))) begin
            m_st[c]   = sd;
            m_lock[c] = 1'b0;
         end
`ifdef BSG_LFSR_BANK_LOCKUP_EN
         else if (m_st[c] == 8'h00) begin
            m_st[c]   = 8'h01;
            m_lock[c] = 1'b1;
         end
`endif
         else if (y[c]) begin
            m_st[c] = lfsr8(m_st[c], 1);
         end
      end
      e.data = {m_st[1], m_st[0]};
      e.lock = m_lock;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      check_eq("u0_data", if0.data_o, g.data);
      check_eq("u0_lock", if0.lockup_o, g.lock);
      check_eq("u0_v", if0.v_o, 2'b11);
   endtask

   logic [7:0] seq0 [6];

   initial begin
      seq0 = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
      reset_n = 1'b0;
      if0.yumi_i = '0; if0.seed_v_i = 1'b0; if0.seed_id_i = '0; if0.seed_i = '0;
      if1.yumi_i = '0; if1.seed_v_i = 1'b0; if1.seed_id_i = '0; if1.seed_i = '0;
      if3.yumi_i = '0; if3.seed_v_i = 1'b0; if3.seed_id_i = '0; if3.seed_i = '0;
      // Warmup-time activity on u2 that must be ignored.
      if2.yumi_i = 2'b11; if2.seed_v_i = 1'b1; if2.seed_id_i = '0; if2.seed_i = 8'h5A;
      model_reset();

      #12;
      check_eq("rst_u0_v", if0.v_o, 2'b11);
      check_eq("rst_u0_rdy", if0.seed_ready_o, 1'b1);
      check_eq("rst_u0_data", if0.data_o, 16'h0101);
      check_eq("rst_u0_lock", if0.lockup_o, 2'b00);
      check_eq("rst_u2_v", if2.v_o, 2'b00);
      check_eq("rst_u2_rdy", if2.seed_ready_o, 1'b0);
      check_eq("rst_u2_data", if2.data_o, 16'h0101);

      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_eq("warm_v_0", if2.v_o, 2'b00);
      for (int i = 1; i <= 2; i++) begin
         @(posedge clk); #1;
         check_eq("warm_v", if2.v_o, 2'b00);
         check_eq("warm_rdy", if2.seed_ready_o, 1'b0);
      end
      @(posedge clk); #1;
      check_eq("warm_done_v", if2.v_o, 2'b11);
      check_eq("warm_done_rdy", if2.seed_ready_o, 1'b1);
      check_eq("warm_done_data", if2.data_o, 16'h2E2E);
      check_eq("u0_hold", if0.data_o, 16'h0101);
      if2.yumi_i = '0; if2.seed_v_i = 1'b0;

      @(negedge clk);
      if1.yumi_i = 2'b10;
      @(posedge clk); #1;
      check_eq("multistep", if1.data_o, 16'h5C01);
      if1.yumi_i = 2'b00;
      @(posedge clk); #1;
      check_eq("multistep_hold", if1.data_o, 16'h5C01);

      @(negedge clk);
      if3.seed_v_i = 1'b1; if3.seed_id_i = 2'd3; if3.seed_i = 8'hAA;
      @(posedge clk); #1;
      check_eq("seed_oob", if3.data_o, 24'h010101);
      @(negedge clk);
      if3.seed_id_i = 2'd2;
      @(posedge clk); #1;
      check_eq("seed_ch2", if3.data_o, 24'hAA0101);
      if3.seed_v_i = 1'b0;

      for (int i = 1; i <= 5; i++) begin
         drive_u0(2'b01, 1'b0, 1'b0, 8'h00);
         check_eq("seq_ch0", if0.data_o[7:0], seq0[i]);
         check_eq("seq_ch1", if0.data_o[15:8], 8'h01);
      end

      drive_u0(2'b10, 1'b1, 1'b1, 8'h5A);
      check_eq("collide_ch1", if0.data_o[15:8], 8'h5A);
      drive_u0(2'b11, 1'b0, 1'b0, 8'h00);

      drive_u0(2'b00, 1'b1, 1'b0, 8'h00);
      check_eq("zero_seed", if0.data_o[7:0], 8'h00);
      drive_u0(2'b00, 1'b0, 1'b0, 8'h00);
`ifdef BSG_LFSR_BANK_LOCKUP_EN
      check_eq("lock_reload", if0.data_o[7:0], 8'h01);
      check_eq("lock_set", if0.lockup_o[0], 1'b1);
`else
      check_eq("zero_stuck", if0.data_o[7:0], 8'h00);
      check_eq("lock_off", if0.lockup_o[0], 1'b0);
`endif
      drive_u0(2'b01, 1'b0, 1'b0, 8'h00);
      drive_u0(2'b00, 1'b1, 1'b0, 8'h11);
      check_eq("lock_clear", if0.lockup_o[0], 1'b0);

      repeat (40) begin
         logic [1:0] y;
         logic       sv;
         logic       sid;
         logic [7:0] sd;
         y   = 2'($urandom_range(0, 3));
         sv  = ($urandom_range(0, 3) == 0);
         sid = 1'($urandom_range(0, 1));
         sd  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         drive_u0(y, sv, sid, sd);
      end

      drive_u0(2'b00, 1'b1, 1'b0, 8'h5A);
      drive_u0(2'b00, 1'b1, 1'b1, 8'hA5);
      if0.seed_v_i = 1'b0; if0.yumi_i = '0;
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("arst_u0_data", if0.data_o, 16'h0101);
      check_eq("arst_u0_v", if0.v_o, 2'b11);
      check_eq("arst_u0_lock", if0.lockup_o, 2'b00);
      check_eq("arst_u2_v", if2.v_o, 2'b00);
      check_eq("arst_u2_rdy", if2.seed_ready_o, 1'b0);
      check_eq("arst_u2_data", if2.data_o, 16'h0101);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      drive_u0(2'b01, 1'b0, 1'b0, 8'h00);
      check_eq("post_rst_ch0", if0.data_o[7:0], 8'hB8);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
